ita_tcdm_lane_splitter: RTL and testbench

Splits one wide HWPE TCDM master port into MP independent narrow memory ports and sits between the ITA streamer and the cluster interconnect. Each lane tracks its own grant, so lanes granted in different cycles complete one wide transaction correctly. Per-lane read-response FIFOs realign out-of-step narrow r_valid returns into a single wide response. An outstanding-read limit guarantees the FIFOs never overflow.

---
 rtl/ita_tcdm_lane_splitter.sv | 140 ++++++++++++++
 tb/tb_ita_tcdm_lane_splitter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_tcdm_lane_splitter.sv
// Splits one wide TCDM master port into MP narrow lanes with per-lane grant tracking
// and realigning read-response FIFOs. Optional sticky err_o via ITA_TCDM_SPLIT_ERR_EN.
module ita_tcdm_lane_splitter #(
  parameter int unsigned AccDataWidth   = 1024,
  parameter int unsigned MemDataWidth   = 64,
  parameter int unsigned MP             = AccDataWidth / MemDataWidth,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   wide_req_i,
  output logic                                   wide_gnt_o,
  input  logic [AddrWidth-1:0]                   wide_add_i,
  input  logic                                   wide_wen_i,
  input  logic [AccDataWidth/8-1:0]              wide_be_i,
  input  logic [AccDataWidth-1:0]                wide_data_i,
  output logic                                   wide_r_valid_o,
  output logic [AccDataWidth-1:0]                wide_r_data_o,
  output logic [MP-1:0]                          tcdm_req_o,
  input  logic [MP-1:0]                          tcdm_gnt_i,
  output logic [MP-1:0][AddrWidth-1:0]           tcdm_add_o,
  output logic [MP-1:0]                          tcdm_wen_o,
  output logic [MP-1:0][MemDataWidth/8-1:0]      tcdm_be_o,
  output logic [MP-1:0][MemDataWidth-1:0]        tcdm_data_o,
  input  logic [MP-1:0][MemDataWidth-1:0]        tcdm_r_data_i,
  input  logic [MP-1:0]                          tcdm_r_valid_i,
  output logic                                   busy_o
`ifdef ITA_TCDM_SPLIT_ERR_EN
  ,
  output logic                                   err_o
`endif
);

  localparam int unsigned MemBytes = MemDataWidth / 8;
  localparam int unsigned PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW     = $clog2(MaxOutstanding + 2);

  logic [MP-1:0]           issued_q, issued_d;
  logic [MP-1:0]           lane_gnt, pend_nz, fifo_full, fifo_nempty, push;
  logic [CntW-1:0]         out_cnt_q, out_cnt_d;
  logic [CntW-1:0]         pend_q [MP];
  logic [CntW-1:0]         pend_d [MP];
  logic [CntW-1:0]         fcnt_q [MP];
  logic [CntW-1:0]         fcnt_d [MP];
  logic [PtrW-1:0]         wr_ptr_q [MP];
  logic [PtrW-1:0]         wr_ptr_d [MP];
  logic [PtrW-1:0]         rd_ptr_q [MP];
  logic [PtrW-1:0]         rd_ptr_d [MP];
  logic [MemDataWidth-1:0] fifo_q [MP][MaxOutstanding];
  logic                    rd_block, rd_gnt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign rd_block       = wide_wen_i & (out_cnt_q == CntW'(MaxOutstanding));
  assign wide_gnt_o     = wide_req_i & ~rd_block & (&(issued_q | tcdm_gnt_i));
  assign rd_gnt         = wide_gnt_o & wide_wen_i;
  assign lane_gnt       = tcdm_req_o & tcdm_gnt_i;
  assign wide_r_valid_o = &fifo_nempty;
  assign busy_o         = (out_cnt_q != '0) | (|issued_q) | wide_req_i;

  for (genvar i = 0; i < MP; i++) begin : g_lane
    assign tcdm_add_o[i]  = wide_add_i + AddrWidth'(i * MemBytes);
    assign tcdm_wen_o[i]  = wide_wen_i;
    assign tcdm_be_o[i]   = wide_be_i[i*MemBytes +: MemBytes];
    assign tcdm_data_o[i] = wide_data_i[i*MemDataWidth +: MemDataWidth];
    assign tcdm_req_o[i]  = wide_req_i & ~issued_q[i] & ~rd_block;
    assign pend_nz[i]     = (pend_q[i] != '0);
    assign fifo_full[i]   = (fcnt_q[i] == CntW'(MaxOutstanding));
    assign fifo_nempty[i] = (fcnt_q[i] != '0);
    // A full lane can still accept when the wide pop frees a slot this cycle.
    assign push[i]        = tcdm_r_valid_i[i] & pend_nz[i] & (~fifo_full[i] | wide_r_valid_o);
    assign wide_r_data_o[i*MemDataWidth +: MemDataWidth] = fifo_q[i][rd_ptr_q[i]];
  end

  always_comb begin
    issued_d  = wide_gnt_o ? '0 : (issued_q | lane_gnt);
    out_cnt_d = out_cnt_q;
    if (rd_gnt && !wide_r_valid_o)      out_cnt_d = out_cnt_q + CntW'(1);
    else if (!rd_gnt && wide_r_valid_o) out_cnt_d = out_cnt_q - CntW'(1);
    for (int i = 0; i < MP; i++) begin
      pend_d[i]   = pend_q[i];
      fcnt_d[i]   = fcnt_q[i];
      wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = wide_r_valid_o ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      if ((lane_gnt[i] & wide_wen_i) && !(tcdm_r_valid_i[i] & pend_nz[i]))
        pend_d[i] = pend_q[i] + CntW'(1);
      else if (!(lane_gnt[i] & wide_wen_i) && (tcdm_r_valid_i[i] & pend_nz[i]))
        pend_d[i] = pend_q[i] - CntW'(1);
      if (push[i] && !wide_r_valid_o)      fcnt_d[i] = fcnt_q[i] + CntW'(1);
      else if (!push[i] && wide_r_valid_o) fcnt_d[i] = fcnt_q[i] - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issued_q  <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < MP; i++) begin
        pend_q[i]   <= '0;
        fcnt_q[i]   <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      issued_q  <= issued_d;
      out_cnt_q <= out_cnt_d;
      for (int i = 0; i < MP; i++) begin
        pend_q[i]   <= pend_d[i];
        fcnt_q[i]   <= fcnt_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // FIFO storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (push[i]) fifo_q[i][wr_ptr_q[i]] <= tcdm_r_data_i[i];
    end
  end

`ifdef ITA_TCDM_SPLIT_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (|(tcdm_r_valid_i & (~pend_nz | fifo_full))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_ita_tcdm_lane_splitter.sv
// Self-checking bench for ita_tcdm_lane_splitter: reset/combinational vector table,
// directed multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_ita_tcdm_lane_splitter;
  localparam int ADW = 256;
  localparam int MDW = 64;
  localparam int NP  = 4;
  localparam int MO  = 2;
  localparam int AW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  wide_req, wide_gnt, wide_wen, wide_rv, busy;
  logic [AW-1:0]         wide_add;
  logic [ADW/8-1:0]      wide_be;
  logic [ADW-1:0]        wide_data, wide_rdata;
  logic [NP-1:0]         tcdm_req, tcdm_gnt, tcdm_wen, tcdm_rv;
  logic [NP-1:0][AW-1:0] tcdm_add;
  logic [NP-1:0][MDW/8-1:0] tcdm_be;
  logic [NP-1:0][MDW-1:0]   tcdm_data, tcdm_rdata;
`ifdef ITA_TCDM_SPLIT_ERR_EN
  logic err;
`endif

  ita_tcdm_lane_splitter #(
    .AccDataWidth(ADW), .MemDataWidth(MDW), .MP(NP), .MaxOutstanding(MO), .AddrWidth(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wide_req_i(wide_req), .wide_gnt_o(wide_gnt), .wide_add_i(wide_add),
    .wide_wen_i(wide_wen), .wide_be_i(wide_be), .wide_data_i(wide_data),
    .wide_r_valid_o(wide_rv), .wide_r_data_o(wide_rdata),
    .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
    .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be), .tcdm_data_o(tcdm_data),
    .tcdm_r_data_i(tcdm_rdata), .tcdm_r_valid_i(tcdm_rv),
    .busy_o(busy)
`ifdef ITA_TCDM_SPLIT_ERR_EN
    , .err_o(err)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic wen, input logic [31:0] addr,
                       input logic [3:0] gnt, input logic [3:0] rv, input logic [255:0] rd);
    wide_req   = req;
    wide_wen   = wen;
    wide_add   = addr;
    tcdm_gnt   = gnt;
    tcdm_rv    = rv;
    tcdm_rdata = rd;
    wide_be    = '1;
    wide_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  gnt;
    logic [31:0] a0, a1, a2, a3;
    logic [3:0]  exp_req;
    logic        exp_gnt;
  } vec_t;

  vec_t vecs [5];

  // Model state for the random phase
  logic [63:0] lpend [4][$];
  logic [63:0] lret  [4][$];

  logic [255:0] d;
  logic [127:0] exp_add;
  logic [31:0]  t_addr, t_be;
  logic [255:0] t_data, exp_d, rdat;
  logic [3:0]   cmask, gnt, rv, exp_req, g;
  bit           active, t_wen, exp_wg, exp_rv, blk, allow;
  int           out_m;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'h1000, 32'h1008, 32'h1010, 32'h1018, 4'hF, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 4'hF, 32'hFFFF_FFF8, 32'h0, 32'h8, 32'h10, 4'hF, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 4'h7, 32'h100, 32'h108, 32'h110, 32'h118, 4'hF, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_2000, 4'hF, 32'h2000, 32'h2008, 32'h2010, 32'h2018, 4'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 4'hE, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0, 32'h8, 4'hF, 1'b0};

    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_wgnt", 256'(wide_gnt), 256'(0));
    chk("rst_rv",   256'(wide_rv),  256'(0));
    chk("rst_req",  256'(tcdm_req), 256'(0));
    chk("rst_busy", 256'(busy),     256'(0));
`ifdef ITA_TCDM_SPLIT_ERR_EN
    chk("rst_err",  256'(err),      256'(0));
`endif

    // Combinational vectors applied while reset holds all state cleared
    for (int k = 0; k < 5; k++) begin
      drive(vecs[k].req, vecs[k].wen, vecs[k].addr, vecs[k].gnt, 0, '0);
      #1;
      chk("vec_add",  256'(tcdm_add), 256'({vecs[k].a3, vecs[k].a2, vecs[k].a1, vecs[k].a0}));
      chk("vec_req",  256'(tcdm_req), 256'(vecs[k].exp_req));
      chk("vec_wgnt", 256'(wide_gnt), 256'(vecs[k].exp_gnt));
      chk("vec_wen",  256'(tcdm_wen), 256'({4{vecs[k].wen}}));
      chk("vec_busy", 256'(busy),     256'(vecs[k].req));
    end
    do_reset();

    // T1: single read, all lanes granted at once
    drive(1, 1, 32'h1000, 4'hF, 0, '0);
    #1;
    chk("t1_req",  256'(tcdm_req), 256'(4'hF));
    chk("t1_wgnt", 256'(wide_gnt), 256'(1));
    chk("t1_add",  256'(tcdm_add), 256'({32'h1018, 32'h1010, 32'h1008, 32'h1000}));
    step();
    d = {64'hDDDD_0003_3333_3333, 64'hCCCC_0002_2222_2222, 64'hBBBB_0001_1111_1111, 64'hAAAA_0000_0000_0000};
    drive(0, 0, 0, 0, 4'hF, d);
    #1;
    chk("t1_rv_early", 256'(wide_rv), 256'(0));
    step();
    drive(0, 0, 0, 0, 0, '0);
    #1;
    chk("t1_rv",    256'(wide_rv), 256'(1));
    chk("t1_rdata", wide_rdata, d);
    step();
    chk("t1_rv_after", 256'(wide_rv), 256'(0));
    chk("t1_busy",     256'(busy),    256'(0));

    // T2: staggered lane grants on a write
    drive(1, 0, 32'h2000, 4'b0001, 0, '0);
    #1;
    chk("t2_req0",  256'(tcdm_req), 256'(4'b1111));
    chk("t2_wgnt0", 256'(wide_gnt), 256'(0));
    step();
    drive(1, 0, 32'h2000, 4'b0110, 0, '0);
    #1;
    chk("t2_req1",  256'(tcdm_req), 256'(4'b1110));
    chk("t2_wgnt1", 256'(wide_gnt), 256'(0));
    step();
    drive(1, 0, 32'h2000, 4'b1000, 0, '0);
    #1;
    chk("t2_req2",  256'(tcdm_req), 256'(4'b1000));
    chk("t2_wgnt2", 256'(wide_gnt), 256'(1));
    step();
    drive(0, 0, 0, 0, 0, '0);
    #1;
    chk("t2_req_idle", 256'(tcdm_req), 256'(0));
    chk("t2_busy",     256'(busy),     256'(0));

    // T3: lane 3 responds three cycles after lanes 0-2
    drive(1, 1, 32'h3000, 4'hF, 0, '0);
    #1;
    chk("t3_wgnt", 256'(wide_gnt), 256'(1));
    step();
    d = {64'h3333_3333_0000_0003, 64'h2222_2222_0000_0002, 64'h1111_1111_0000_0001, 64'h0000_0000_0000_0010};
    drive(0, 0, 0, 0, 4'b0111, d);
    #1;
    chk("t3_rv_a", 256'(wide_rv), 256'(0));
    step();
    drive(0, 0, 0, 0, 0, '0);
    #1;
    chk("t3_rv_b", 256'(wide_rv), 256'(0));
    step();
    chk("t3_rv_c", 256'(wide_rv), 256'(0));
    step();
    drive(0, 0, 0, 0, 4'b1000, d);
    #1;
    chk("t3_rv_d", 256'(wide_rv), 256'(0));
    step();
    drive(0, 0, 0, 0, 0, '0);
    #1;
    chk("t3_rv",    256'(wide_rv), 256'(1));
    chk("t3_rdata", wide_rdata, d);
    step();
    chk("t3_nodup", 256'(wide_rv), 256'(0));
    step();
    chk("t3_nodup2", 256'(wide_rv), 256'(0));
    chk("t3_busy",   256'(busy),    256'(0));

    // T4: third back-to-back read is held by the outstanding limit
    drive(1, 1, 32'h4000, 4'hF, 0, '0);
    #1;
    chk("t4_wgnt_a", 256'(wide_gnt), 256'(1));
    step();
    drive(1, 1, 32'h4040, 4'hF, 0, '0);
    #1;
    chk("t4_wgnt_b", 256'(wide_gnt), 256'(1));
    step();
    drive(1, 1, 32'h4080, 4'hF, 0, '0);
    #1;
    chk("t4_req_blk",  256'(tcdm_req), 256'(0));
    chk("t4_wgnt_blk", 256'(wide_gnt), 256'(0));
    chk("t4_busy",     256'(busy),     256'(1));
    step();
    chk("t4_req_blk2", 256'(tcdm_req), 256'(0));
    step();
    d = {4{64'h4444_AAAA_5555_BBBB}};
    drive(1, 1, 32'h4080, 4'hF, 4'hF, d);
    #1;
    chk("t4_req_blk3", 256'(tcdm_req), 256'(0));
    step();
    drive(1, 1, 32'h4080, 4'hF, 0, '0);
    #1;
    chk("t4_rv",      256'(wide_rv),  256'(1));
    chk("t4_rdata",   wide_rdata,     d);
    chk("t4_req_blk4", 256'(tcdm_req), 256'(0));
    step();
    chk("t4_req_go",  256'(tcdm_req), 256'(4'hF));
    chk("t4_wgnt_go", 256'(wide_gnt), 256'(1));
    step();
    drive(0, 0, 0, 0, 0, '0);
    #1;
    chk("t4_busy_out", 256'(busy), 256'(1));

    // T6: reset with two reads outstanding, then stale lane responses
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 4'hF, {4{64'hDEAD_BEEF_DEAD_BEEF}});
    #1;
    chk("t6_busy0", 256'(busy), 256'(0));
    step();
    drive(0, 0, 0, 0, 0, '0);
    #1;
    chk("t6_rv",   256'(wide_rv), 256'(0));
    chk("t6_busy", 256'(busy),    256'(0));
`ifdef ITA_TCDM_SPLIT_ERR_EN
    chk("t6_err",  256'(err),     256'(1));
`endif
    step();
    chk("t6_rv2", 256'(wide_rv), 256'(0));

    // Randomized traffic against the queue model
    do_reset();
    active = 0;
    cmask  = '0;
    out_m  = 0;
    t_wen  = 0;
    t_addr = '0;
    t_data = '0;
    t_be   = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      allow = (cyc < 3700);
      if (!active && allow && ($urandom_range(3) != 0)) begin
        active = 1;
        cmask  = '0;
        t_wen  = 1'($urandom_range(1));
        t_addr = ($urandom_range(7) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
        t_be   = $urandom;
        for (int w = 0; w < 8; w++) t_data[w*32 +: 32] = $urandom;
      end
      gnt = 4'($urandom);
      for (int i = 0; i < NP; i++) begin
        rv[i] = 1'b0;
        rdat[i*64 +: 64] = {$urandom, $urandom};
        if (lpend[i].size() > 0) begin
          if ($urandom_range(1) == 1) begin
            rv[i] = 1'b1;
            rdat[i*64 +: 64] = lpend[i][0];
          end
        end else if ($urandom_range(15) == 0) begin
          rv[i] = 1'b1;
        end
      end
      wide_req   = active;
      wide_wen   = t_wen;
      wide_add   = t_addr;
      wide_be    = t_be;
      wide_data  = t_data;
      tcdm_gnt   = gnt;
      tcdm_rv    = rv;
      tcdm_rdata = rdat;
      #1;
      blk     = t_wen && (out_m == MO);
      exp_req = (active && !blk) ? ~cmask : 4'h0;
      exp_wg  = active && !blk && ((cmask | gnt) == 4'hF);
      exp_rv  = 1;
      exp_d   = '0;
      for (int i = 0; i < NP; i++) begin
        if (lret[i].size() == 0) exp_rv = 0;
        else exp_d[i*64 +: 64] = lret[i][0];
      end
      chk("rnd_req",  256'(tcdm_req), 256'(exp_req));
      chk("rnd_wgnt", 256'(wide_gnt), 256'(exp_wg));
      chk("rnd_rv",   256'(wide_rv),  256'(exp_rv));
      chk("rnd_busy", 256'(busy),     256'((out_m != 0) || (cmask != 0) || active));
      if (exp_rv) chk("rnd_rdata", wide_rdata, exp_d);
      if (active) begin
        for (int i = 0; i < NP; i++) exp_add[i*32 +: 32] = t_addr + 32'(8 * i);
        chk("rnd_add",  256'(tcdm_add),  256'(exp_add));
        chk("rnd_data", 256'(tcdm_data), t_data);
        chk("rnd_be",   256'(tcdm_be),   256'(t_be));
        chk("rnd_wen",  256'(tcdm_wen),  256'({4{t_wen}}));
      end
      for (int i = 0; i < NP; i++) begin
        if (rv[i] && (lpend[i].size() > 0)) lret[i].push_back(lpend[i].pop_front());
      end
      g = exp_req & gnt;
      for (int i = 0; i < NP; i++) begin
        if (g[i] && t_wen) lpend[i].push_back({$urandom, $urandom});
      end
      cmask = cmask | g;
      if (exp_wg) begin
        if (t_wen) out_m++;
        active = 0;
        cmask  = '0;
      end
      if (exp_rv) begin
        for (int i = 0; i < NP; i++) void'(lret[i].pop_front());
        out_m--;
      end
      step();
    end
    drive(0, 0, 0, 0, 0, '0);
    #1;
    chk("drain_model", 256'({active, (out_m != 0)}), 256'(0));
    chk("drain_busy",  256'(busy), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
